// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux4 block.
package stream_demux_pkg;

  localparam int NUM_PORTS = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef logic [1:0] port_idx_t;

endpackage

// File: rtl/stream_demux4_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Count up on inc, hold at all-ones, clear to zero on reset or clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/stream_demux4.sv
// One-entry registered 1-to-4 stream demultiplexer with valid/ready handshakes.
// Optional per-port saturating transfer counters are built when the macro
// STREAM_DEMUX4_COUNT_EN is defined; otherwise the count outputs read 0.
module stream_demux4
  import stream_demux_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE-1:0]      in_data,
  input  logic [1:0]           in_select,
  output logic [NUM_PORTS-1:0] out_valid,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic [SIZE-1:0]      out_data,
  input  logic                 count_clear,
  output logic [CNT_W-1:0]     count_0,
  output logic [CNT_W-1:0]     count_1,
  output logic [CNT_W-1:0]     count_2,
  output logic [CNT_W-1:0]     count_3
);

  state_t          state_reg;
  state_t          state_next;
  logic [SIZE-1:0] data_reg;
  port_idx_t       sel_reg;
  logic            accept;
  logic            drain;

  // Ready when empty, or when the held word leaves this same cycle.
  assign in_ready = (state_reg == ST_EMPTY) || out_ready[sel_reg];
  assign accept   = in_valid && in_ready;
  assign drain    = (state_reg == ST_FULL) && out_ready[sel_reg];

  // Next-state logic: fill on accept, empty on drain without a refill.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (drain && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Holding register for the word and its destination, loaded only on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      sel_reg  <= '0;
    end else if (accept) begin
      data_reg <= in_data;
      sel_reg  <= in_select;
    end
  end

  assign out_data = data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
      assign out_valid[gi] = (state_reg == ST_FULL) && (sel_reg == port_idx_t'(gi));
    end
  endgenerate

`ifdef STREAM_DEMUX4_COUNT_EN
  logic [CNT_W-1:0] counts [NUM_PORTS];

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_count
      sat_counter #(
        .CNT_W(CNT_W)
      ) u_sat_counter (
        .clk   (clk),
        .reset (reset),
        .clear (count_clear),
        .inc   (out_valid[gi] && out_ready[gi]),
        .count (counts[gi])
      );
    end
  endgenerate

  assign count_0 = counts[0];
  assign count_1 = counts[1];
  assign count_2 = counts[2];
  assign count_3 = counts[3];
`else
  // Counters not built: clear input has no effect.
  logic unused_count_clear;
  logic unused_drain;
  assign unused_count_clear = count_clear;
  assign unused_drain       = drain;
  assign count_0 = '0;
  assign count_1 = '0;
  assign count_2 = '0;
  assign count_3 = '0;
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4 with a queue scoreboard.
// Count expectations follow STREAM_DEMUX4_COUNT_EN (zero when undefined).
module tb_stream_demux4;

  localparam int SIZE  = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic [SIZE-1:0] data;
    logic [1:0]      sel;
  } item_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SIZE-1:0]  in_data = '0;
  logic [1:0]       in_select = '0;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = 4'b0000;
  logic [SIZE-1:0]  out_data;
  logic             count_clear = 1'b0;
  logic [CNT_W-1:0] count_0, count_1, count_2, count_3;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  item_t            sb[$];
  logic [CNT_W-1:0] exp_count [4] = '{default: '0};

  stream_demux4 #(
    .SIZE (SIZE),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_select  (in_select),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count_clear(count_clear),
    .count_0    (count_0),
    .count_1    (count_1),
    .count_2    (count_2),
    .count_3    (count_3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard: at each falling edge predict the transfers of the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      exp_count = '{default: '0};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          item_t it;
          tests_run++;
          if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL drain_unexpected: port %0d data %h, required no output", i, out_data);
          end else begin
            it = sb.pop_front();
            if (out_data !== it.data || i[1:0] !== it.sel) begin
              tests_failed++;
              $display("FAIL drain: got port %0d data %h, required port %0d data %h",
                       i, out_data, it.sel, it.data);
            end else begin
              $display("[TB] drain port %0d data %h", i, out_data);
            end
          end
`ifdef STREAM_DEMUX4_COUNT_EN
          if (!count_clear && exp_count[i] != {CNT_W{1'b1}}) exp_count[i] = exp_count[i] + 1'b1;
`endif
        end
      end
`ifdef STREAM_DEMUX4_COUNT_EN
      if (count_clear) exp_count = '{default: '0};
`endif
      if (in_valid && in_ready) begin
        item_t nw;
        nw.data = in_data;
        nw.sel  = in_select;
        sb.push_back(nw);
        $display("[TB] accept sel %0d data %h", in_select, in_data);
      end
    end
  end

  // Offer one word and return just after the edge that accepts it.
  task automatic send(input logic [SIZE-1:0] d, input logic [1:0] s);
    bit ok;
    ok = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_select = s;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counts(input string tag);
    logic [CNT_W-1:0] got [4];
    @(negedge clk);
    got[0] = count_0; got[1] = count_1; got[2] = count_2; got[3] = count_3;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got[i] !== exp_count[i]) begin
        tests_failed++;
        $display("FAIL %s_count_%0d: got %0d, required %0d", tag, i, got[i], exp_count[i]);
      end
    end
    $display("[TB] %s counts %0d %0d %0d %0d", tag, got[0], got[1], got[2], got[3]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run += 3;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL reset_out_valid: got %b, required 0000", out_valid); end
    if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
    @(posedge clk); #1;
    check_counts("reset");
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    out_ready = 4'b1111;
    send(32'hDEADBEEF, 2'd2);
    in_valid = 1'b0;
    @(negedge clk);
    tests_run += 2;
    if (out_valid !== 4'b0100) begin tests_failed++; $display("FAIL single_valid: got %b, required 0100", out_valid); end
    if (out_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_data: got %h, required deadbeef", out_data); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL single_valid_after: got %b, required 0000", out_valid); end
    @(posedge clk); #1;
    check_counts("single");
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int start;
    out_ready = 4'b1111;
    start = cycle;
    for (int k = 0; k < 8; k++) send(32'hA000_0000 + k, k[1:0]);
    tests_run++;
    if (cycle - start !== 8) begin
      tests_failed++;
      $display("FAIL stream_throughput: got %0d cycles, required 8", cycle - start);
    end
    idle(2);
    check_counts("stream");
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    send(32'h12345678, 2'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run += 3;
      if (out_valid !== 4'b0010) begin tests_failed++; $display("FAIL stall_valid: cycle %0d got %b, required 0010", k, out_valid); end
      if (out_data !== 32'h12345678) begin tests_failed++; $display("FAIL stall_data: cycle %0d got %h, required 12345678", k, out_data); end
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready: cycle %0d got %b, required 0", k, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 4'b1111;
    idle(2);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL stall_release: got %b, required 0000", out_valid); end
    @(posedge clk); #1;
    check_counts("stall");
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0000;
    send(32'hAAAA5555, 2'd3);
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b1000) begin tests_failed++; $display("FAIL midreset_pre: got %b, required 1000", out_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 4'b1111;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL midreset_valid: got %b, required 0000", out_valid); end
    @(posedge clk); #1;
    check_counts("midreset");
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    out_ready = 4'b1111;
    for (int k = 0; k < (1 << CNT_W) + 4; k++) send(32'hC000_0000 + k, 2'd0);
    idle(2);
    check_counts("saturate");
    @(posedge clk); #1;
    send(32'hC1EA_0000, 2'd0);
    in_valid    = 1'b0;
    count_clear = 1'b1;
    @(posedge clk); #1;
    count_clear = 1'b0;
    check_counts("clear");
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    idle(2);
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stream_demux4.md
# stream_demux4

One-entry registered 1-to-4 demultiplexer with valid/ready handshakes. It steers a single `SIZE`-bit input stream to one of four destination ports chosen by a 2-bit select. It is the fan-out counterpart of the datapath's 4-to-1 result selector and sits between a single producer (e.g. a writeback or store path) and four consumers (register file, data memory, CSR block, I/O). Optional per-port transfer counters provide debug visibility.

## Interface
Parameters:
- `SIZE`, 32: data width in bits.
- `CNT_W`, 16: width of each per-port transfer counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_ready`  output  1  block accepts the word this cycle.
- `in_data`  input  SIZE  input word.
- `in_select`  input  2  destination port index, 0..3; sampled with `in_data`.
- `out_valid`  output  4  per-port valid; one-hot or all-zero.
- `out_ready`  input  4  per-port consumer ready.
- `out_data`  output  SIZE  held word, shared by all ports; meaningful only for the port whose `out_valid` is set.
- `count_clear`  input  1  clears all counters.
- `count_0`..`count_3`  output  CNT_W each  completed transfers per port.

## Operation
- The FSM has two states:
  - `EMPTY`: no word held.
  - `FULL`: word held in `data_q`, destination in `sel_q`.
- `in_ready = (state == EMPTY) || out_ready[sel_q]`. This gives pass-through readiness, so a word is accepted while the held word drains.
- A word is accepted when `in_valid && in_ready`. On accept, `data_q <= in_data`, `sel_q <= in_select`, state becomes `FULL`.
- A word is drained when state is `FULL` and `out_ready[sel_q]` is high.
- State transitions:
  - `EMPTY` + accept → `FULL`.
  - `FULL` + drain + no accept → `EMPTY`.
  - `FULL` + drain + accept → `FULL`, reloaded with the new word.
  - `FULL` without drain → `FULL`, held.
- `out_valid[i] = (state == FULL) && (sel_q == i)`. `out_data = data_q`.
- While `out_valid[i]` is high and `out_ready[i]` is low, `out_data` and `out_valid` must not change.
- `out_ready` bits of non-selected ports are ignored.
- `in_select` is ignored when no accept occurs. No combinational path from `in_data` or `in_select` to any output.
- Counter `i` increments on each drain to port `i`.
  - Counters saturate at all-ones; they never wrap.
  - `count_clear` has priority over an increment in the same cycle: the counter becomes 0 and that drain is not counted.

## Timing
- Reset values: state `EMPTY`; `out_valid = 4'b0000`; `out_data = 0`; `sel_q = 0`; all counters 0. Because state is `EMPTY`, `in_ready` reads 1 in the cycle after reset.
- A reset asserted mid-transfer discards the held word. No drain is signalled for it.
- Latency: a word accepted at edge N is presented on `out_valid`/`out_data` after edge N.
- Throughput: one word per clock when the selected consumer holds `out_ready` high. Switching port between consecutive words costs no bubble.
- Backpressure: if `out_ready[sel_q]` is low, then `in_ready` is low in the same cycle.

## Configuration
- Macro: `STREAM_DEMUX4_COUNT_EN`.
- Defined: the four saturating counters and the `count_clear` behaviour are implemented as described above.
- Undefined: no counter registers are instantiated. `count_0`..`count_3` are tied to constant 0 and `count_clear` is ignored. The port list is identical in both builds.

## Structure
- Shared package `stream_demux_pkg`:
  - `NUM_PORTS = 4`.
  - state enum with `ST_EMPTY` and `ST_FULL`.
  - port index typedef, 2 bits.
- One sub-module, `sat_counter` (`CNT_W`, `clk`, `reset`, `clear`, `inc`, `count`), instantiated four times under the macro.

## Test plan
- Reset, then idle → `in_ready=1`, `out_valid=0000`, `out_data=0`, counts 0.
- Send `0xDEADBEEF` with select 2, `out_ready=1111` → `out_valid=0100` for one cycle, `out_data=0xDEADBEEF`, `count_2=1`.
- Stream 8 words with selects 0,1,2,3,0,1,2,3, all ready → one output per clock in order, each count = 2.
- Send `0x12345678` with select 1 while `out_ready[1]=0` for 5 cycles and other ready bits high → `out_valid=0010` and `out_data` stable for all 5 cycles, `in_ready=0`; after ready rises, one drain.
- Assert reset while `FULL` with a stalled word → after the edge `out_valid=0000`, held word lost, counters 0.
- With the macro defined: force `count_0` to all-ones via `2^CNT_W` drains → it stays saturated. Then `count_clear` together with a port-0 drain → `count_0=0`.
